// File: rtl/issue_unit.sv
// Single-issue scheduler between the integer, load/store, multiply and divide
// issue queues and their functional units. Each cycle at most one ready queue
// is granted, and only if the CDB slot its result will need is still free.
// Future CDB occupancy is tracked in a reservation shift register; the
// non-pipelined divider's busy time is tracked with a down-counter.
module issue_unit #(
    parameter int unsigned INT_LAT = 1,
    parameter int unsigned LS_LAT  = 2,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iq_int_rdy,
    input  logic               iq_ls_rdy,
    input  logic               iq_mul_rdy,
    input  logic               iq_div_rdy,
    input  logic               cdb_flush,
    output logic               iu_int_r_en,
    output logic               iu_ls_r_en,
    output logic               iu_mul_r_en,
    output logic               iu_div_r_en,
    output logic               div_busy,
    output logic [DIV_LAT-1:0] cdb_slot_vec
);

    localparam int unsigned CntW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [CntW-1:0] DivReload = CntW'(DIV_LAT - 1);

    // slot[k] = 1: the CDB is already claimed k cycles from now
    logic [DIV_LAT:1] slot_q, slot_d;
    logic [CntW-1:0]  div_cnt_q, div_cnt_d;
    // lru_q = 0 favours integer, 1 favours load/store
    logic             lru_q, lru_d;

    logic int_ok, ls_ok, mul_ok, div_ok;
    logic int_g, ls_g, mul_g, div_g;
    logic no_issue;

    assign div_busy     = (div_cnt_q != '0);
    assign cdb_slot_vec = slot_q;

    // No issue at all during reset or a mispredict flush
    assign no_issue = reset | cdb_flush;

    // Per-requester eligibility: ready and its completion slot still free
    always_comb begin
        int_ok = iq_int_rdy & ~slot_q[INT_LAT] & ~no_issue;
        ls_ok  = iq_ls_rdy  & ~slot_q[LS_LAT]  & ~no_issue;
        mul_ok = iq_mul_rdy & ~slot_q[MUL_LAT] & ~no_issue;
        div_ok = iq_div_rdy & ~slot_q[DIV_LAT] & ~no_issue & ~div_busy;
    end

    // Fixed priority div > mul > {int, ls}; int/ls tie broken by the LRU bit
    always_comb begin
        div_g = div_ok;
        mul_g = mul_ok & ~div_ok;
        int_g = 1'b0;
        ls_g  = 1'b0;
        if (!div_ok && !mul_ok) begin
            if (int_ok && ls_ok) begin
                int_g = ~lru_q;
                ls_g  = lru_q;
            end else begin
                int_g = int_ok;
                ls_g  = ls_ok;
            end
        end
    end

    assign iu_int_r_en = int_g;
    assign iu_ls_r_en  = ls_g;
    assign iu_mul_r_en = mul_g;
    assign iu_div_r_en = div_g;

    // Reservation shift: a grant of latency L lands in slot L-1 after the edge,
    // which is the same CDB cycle as the pre-shift slot L it was checked against.
    // The divide reservation is placed in the top slot.
    always_comb begin
        slot_d = '0;
        for (int unsigned k = 1; k < DIV_LAT; k++) begin
            slot_d[k] = slot_q[k+1]
                      | (int_g & (INT_LAT == k + 1))
                      | (ls_g  & (LS_LAT  == k + 1))
                      | (mul_g & (MUL_LAT == k + 1));
        end
        slot_d[DIV_LAT] = div_g;
    end

    // Divider occupancy: reload on a divide grant, otherwise count down to zero
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_g) begin
            div_cnt_d = DivReload;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
    end

    // LRU moves only when int or ls wins; the loser becomes favoured
    always_comb begin
        lru_d = lru_q;
        if (int_g) begin
            lru_d = 1'b1;
        end else if (ls_g) begin
            lru_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops every reservation
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            div_cnt_q <= '0;
            lru_q     <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            div_cnt_q <= div_cnt_d;
            lru_q     <= lru_d;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Randomized and scenario-driven bench for issue_unit. The reference model
// books absolute CDB cycles in an array and keeps the earliest cycle at which
// the divider is free again.
module tb_issue_unit;

    localparam int INT_L = 1;
    localparam int LS_L  = 2;
    localparam int MUL_L = 4;
    localparam int DIV_L = 7;
    localparam int MAXC  = 8192;

    logic clk = 1'b0;
    logic reset, iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy, cdb_flush;
    logic iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en, div_busy;
    logic [DIV_L-1:0] cdb_slot_vec;

    always #5 clk = ~clk;

    issue_unit #(
        .INT_LAT(INT_L),
        .LS_LAT (LS_L),
        .MUL_LAT(MUL_L),
        .DIV_LAT(DIV_L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iq_int_rdy  (iq_int_rdy),
        .iq_ls_rdy   (iq_ls_rdy),
        .iq_mul_rdy  (iq_mul_rdy),
        .iq_div_rdy  (iq_div_rdy),
        .cdb_flush   (cdb_flush),
        .iu_int_r_en (iu_int_r_en),
        .iu_ls_r_en  (iu_ls_r_en),
        .iu_mul_r_en (iu_mul_r_en),
        .iu_div_r_en (iu_div_r_en),
        .div_busy    (div_busy),
        .cdb_slot_vec(cdb_slot_vec)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit cdb_taken[MAXC];   // absolute cycle -> CDB booked
    int cyc      = 0;
    int div_free = 0;      // first cycle a new divide may issue
    bit lru_ls   = 1'b0;   // 1: load/store favoured
    bit known    = 1'b0;   // state defined once a reset edge has been seen

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit r, input bit fl, input bit i, input bit l, input bit m,
                        input bit d);
        bit ei, el, em, ed, gi, gl, gm, gd;
        logic [DIV_L-1:0] ev;
        @(negedge clk);
        reset      = r;
        cdb_flush  = fl;
        iq_int_rdy = i;
        iq_ls_rdy  = l;
        iq_mul_rdy = m;
        iq_div_rdy = d;
        #1;
        ei = i && !r && !fl && !cdb_taken[cyc + INT_L];
        el = l && !r && !fl && !cdb_taken[cyc + LS_L];
        em = m && !r && !fl && !cdb_taken[cyc + MUL_L];
        ed = d && !r && !fl && !cdb_taken[cyc + DIV_L] && (cyc >= div_free);
        gd = ed;
        gm = em && !gd;
        gi = 1'b0;
        gl = 1'b0;
        if (!gd && !gm) begin
            if (ei && el) begin
                gi = !lru_ls;
                gl = lru_ls;
            end else begin
                gi = ei;
                gl = el;
            end
        end
        if (known) begin
            check("int_grant", iu_int_r_en, gi);
            check("ls_grant", iu_ls_r_en, gl);
            check("mul_grant", iu_mul_r_en, gm);
            check("div_grant", iu_div_r_en, gd);
            for (int k = 1; k <= DIV_L; k++) ev[k-1] = cdb_taken[cyc + k];
            check("slot_vec", cdb_slot_vec, ev);
            check("div_busy", div_busy, cyc < div_free);
        end else begin
            check("grants_in_reset", {iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en}, 0);
        end
        @(posedge clk);
        if (r) begin
            for (int k = 1; k <= DIV_L + 1; k++) cdb_taken[cyc + k] = 1'b0;
            div_free = 0;
            lru_ls   = 1'b0;
            known    = 1'b1;
        end else begin
            // divide result is booked one cycle beyond its latency
            if (gd) begin
                cdb_taken[cyc + DIV_L + 1] = 1'b1;
                div_free = cyc + DIV_L;
            end
            if (gm) cdb_taken[cyc + MUL_L] = 1'b1;
            if (gi) begin
                cdb_taken[cyc + INT_L] = 1'b1;
                lru_ls = 1'b1;
            end
            if (gl) begin
                cdb_taken[cyc + LS_L] = 1'b1;
                lru_ls = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cdb_flush = 1'b0;
        {iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy} = '0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // all requesters at once: divide wins, then shows in the top slot
        step(0, 0, 1, 1, 1, 1);
        idle(8);
        // continuous divide requests
        step(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 16; j++) step(0, 0, 0, 0, 0, 1);
        // multiply result blocks a later integer
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(4);
        // int/ls alternation
        step(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) step(0, 0, 1, 1, 0, 0);
        idle(3);
        // flush with requests pending
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        for (int j = 0; j < 4; j++) step(0, 0, 1, 1, 1, 0);
        // reset mid-divide
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(8);
        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
